fix_field_extractor: RTL and testbench
======================================

Name: fix_field_extractor

Overview:
Sits directly downstream of the FIX byte parser and consumes its byte stream with per-byte tag/value strobes. It converts each ASCII decimal tag to binary and captures the value bytes into a fixed-width buffer. Each completed tag=value field is presented as one record on a valid/ready interface to the message decoder. The parser has no backpressure, so a completed field is dropped and counted when the output slot is occupied.

Parameters:
TAG_W, 16, width of binary tag; tags above 2^TAG_W-1 saturate.
MAX_VAL_LEN, 16, maximum stored value bytes per field.
LEN_W, $clog2(MAX_VAL_LEN+1), derived width of the length field; not overridden.

Ports:
clk  in  1  single clock; all logic on posedge.
rst  in  1  synchronous reset, active-low (0 = reset).
data_i  in  8  byte from parser; qualified by strobes.
tag_s_i  in  1  data_i is a tag byte.
tag_e_i  in  1  tag terminator ('=') seen; data_i ignored.
value_s_i  in  1  data_i is a value byte.
value_e_i  in  1  field terminator (SOH) seen; data_i ignored.
field_valid_o  out  1  output record valid.
field_ready_i  in  1  consumer accepts the record.
field_tag_o  out  TAG_W  binary tag.
field_len_o  out  LEN_W  stored value bytes, 0..MAX_VAL_LEN.
field_data_o  out  8*MAX_VAL_LEN  value bytes; byte 0 in [7:0]; unused bytes are 0.
field_err_o  out  4  [0] non-digit in tag, [1] tag overflow, [2] value truncated, [3] empty tag.
drop_o  out  1  one-cycle pulse when a completed field is discarded because the slot is full.
proto_err_o  out  1  one-cycle pulse on a strobe-sequence violation.
drop_cnt_o  out  16  saturating count of drop_o pulses.

Behaviour:
- Reset (rst==0 at posedge) sets state to IDLE and clears all accumulators. All outputs go to 0, including field_valid_o and drop_cnt_o. A field in progress or held at the output is discarded.
- Input contract: at most one strobe per cycle. More than one strobe in a cycle is a protocol violation.
- FSM states: IDLE, TAG, VALUE.
  - IDLE:
    - tag_s_i: clear the accumulators and value buffer, load the first digit, go to TAG.
    - value_s_i, value_e_i or tag_e_i: pulse proto_err_o and stay in IDLE.
  - TAG:
    - tag_s_i: acc = acc*10 + (data_i - 8'h30).
    - tag_e_i: go to VALUE. If zero digits were seen, set err[3].
    - value_s_i or value_e_i: pulse proto_err_o, abort the field, go to IDLE.
  - VALUE:
    - value_s_i: if len < MAX_VAL_LEN, store data_i at byte[len] and increment len. Otherwise set err[2] and discard the byte.
    - value_e_i: commit the field, go to IDLE.
    - tag_s_i or tag_e_i: pulse proto_err_o, abort the field, go to IDLE.
  - Multiple strobes in one cycle, in any state: proto_err_o pulse, abort, go to IDLE.
- Digit rules:
  - A tag byte outside 8'h30..8'h39 sets err[0]; the accumulator is unchanged for that byte.
  - The product is computed in TAG_W+4 bits. A result above 2^TAG_W-1 sets err[1], and the tag is held at all-ones for the rest of the field.
- Commit happens in the cycle of value_e_i; the record is visible on the next cycle.
  - The slot is free if field_valid_o==0, or if field_valid_o && field_ready_i in the same cycle.
  - Free slot: load tag/len/data/err and set field_valid_o=1 on the next cycle. Latency from value_e_i to valid is 1 cycle.
  - Full slot: the held record stays unchanged, drop_o pulses, drop_cnt_o increments and saturates at 16'hFFFF.
- Handshake:
  - The record transfers on field_valid_o && field_ready_i. field_valid_o then clears unless a same-cycle commit reloads it.
  - Record outputs are stable while valid && !ready.
- Fields with err bits set are still emitted; the consumer decides what to do with them.

Decomposition:
- fix_pkg holds:
  - ASCII constants: SOH 8'h01, SEP 8'h3D, DIG0 8'h30, DIG9 8'h39.
  - State enum fix_fx_state_t {IDLE, TAG, VALUE}.
  - Error bit index constants ERR_BAD_DIGIT=0, ERR_TAG_OVF=1, ERR_TRUNC=2, ERR_EMPTY_TAG=3.
- One sub-module, fix_ascii_dec_acc. It is combinational, parameterised by TAG_W, and takes acc, data_i and the current saturated flag. It returns next acc, is_digit and ovf.

Test Plan:
- Stream "35=D<SOH>" with ready=1: tag 35, len 1, data[7:0]=8'h44, err 4'b0000, valid 1 cycle after value_e.
- Tag "9999999=A<SOH>", TAG_W=16: tag 16'hFFFF, err[1]=1, len 1.
- Tag "3X=1<SOH>": err[0]=1, tag 3. Then "=5<SOH>" entered from IDLE gives proto_err_o pulse on '=' and the following value strobes, and no record.
- 20-byte value "ABCDEFGHIJKLMNOPQRST", MAX_VAL_LEN=16: len 16, bytes "A".."P", err[2]=1.
- ready=0, fields "8=F<SOH>" then "9=5<SOH>": first record held stable, drop_o pulses at the second value_e, drop_cnt_o=1. Raising ready on the second field's value_e cycle instead yields both records with no drop.
- rst=0 for 1 cycle in mid-VALUE with a record held: valid=0, drop_cnt_o=0. The next field "55=2<SOH>" is emitted clean with err 0.

Source files
------------

// File: rtl/fix_pkg.sv
// rtl/fix_pkg.sv - shared constants and types for the FIX field extractor
package fix_pkg;

  localparam logic [7:0] SOH  = 8'h01;
  localparam logic [7:0] SEP  = 8'h3D;
  localparam logic [7:0] DIG0 = 8'h30;
  localparam logic [7:0] DIG9 = 8'h39;

  typedef enum logic [1:0] {
    IDLE,
    TAG,
    VALUE
  } fix_fx_state_t;

  localparam int ERR_BAD_DIGIT = 0;
  localparam int ERR_TAG_OVF   = 1;
  localparam int ERR_TRUNC     = 2;
  localparam int ERR_EMPTY_TAG = 3;

  function automatic logic fix_is_digit(input logic [7:0] b);
    return (b >= DIG0) && (b <= DIG9);
  endfunction

  function automatic logic fix_is_delim(input logic [7:0] b);
    return (b == SOH) || (b == SEP);
  endfunction

endpackage

// File: rtl/fix_ascii_dec_acc.sv
// rtl/fix_ascii_dec_acc.sv - one step of ASCII decimal to binary accumulation
module fix_ascii_dec_acc
  import fix_pkg::*;
#(
  parameter int TAG_W = 16
) (
  input  logic [TAG_W-1:0] acc_i,
  input  logic [7:0]       data_i,
  input  logic             sat_i,
  output logic [TAG_W-1:0] acc_o,
  output logic             is_digit_o,
  output logic             ovf_o
);

  // Four spare bits hold acc*10+9 for any TAG_W-bit acc.
  localparam int PW = TAG_W + 4;

  logic [PW-1:0] prod;
  logic [7:0]    digit;

  always_comb begin
    is_digit_o = fix_is_digit(data_i);
    digit      = data_i - DIG0;
    prod       = PW'(acc_i) * PW'(10) + PW'(digit[3:0]);
    ovf_o      = is_digit_o && !sat_i && (prod[PW-1:TAG_W] != '0);
    acc_o      = acc_i;
    if (sat_i || ovf_o) begin
      acc_o = '1;
    end else if (is_digit_o) begin
      acc_o = prod[TAG_W-1:0];
    end
  end

endmodule

// File: rtl/fix_field_extractor.sv
// rtl/fix_field_extractor.sv - turns parser tag/value strobes into one record per FIX field
module fix_field_extractor
  import fix_pkg::*;
#(
  parameter int TAG_W       = 16,
  parameter int MAX_VAL_LEN = 16,
  parameter int LEN_W       = $clog2(MAX_VAL_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               data_i,
  input  logic                     tag_s_i,
  input  logic                     tag_e_i,
  input  logic                     value_s_i,
  input  logic                     value_e_i,
  output logic                     field_valid_o,
  input  logic                     field_ready_i,
  output logic [TAG_W-1:0]         field_tag_o,
  output logic [LEN_W-1:0]         field_len_o,
  output logic [8*MAX_VAL_LEN-1:0] field_data_o,
  output logic [3:0]               field_err_o,
  output logic                     drop_o,
  output logic                     proto_err_o,
  output logic [15:0]              drop_cnt_o
);

  fix_fx_state_t            state_q;
  logic [TAG_W-1:0]         acc_q;
  logic                     sat_q;
  logic                     digit_seen_q;
  logic [LEN_W-1:0]         len_q;
  logic [8*MAX_VAL_LEN-1:0] buf_q;
  logic [3:0]               err_q;

  logic                     valid_q;
  logic [TAG_W-1:0]         otag_q;
  logic [LEN_W-1:0]         olen_q;
  logic [8*MAX_VAL_LEN-1:0] odata_q;
  logic [3:0]               oerr_q;
  logic                     drop_q;
  logic                     perr_q;
  logic [15:0]              dcnt_q;

  logic [TAG_W-1:0]         acc_d;
  logic                     is_digit;
  logic                     ovf;
  logic                     multi;
  logic                     slot_free;

  // A new field starts from a zero accumulator, so IDLE feeds zeros in.
  fix_ascii_dec_acc #(.TAG_W(TAG_W)) u_dec (
    .acc_i      ((state_q == IDLE) ? '0 : acc_q),
    .data_i     (data_i),
    .sat_i      ((state_q == IDLE) ? 1'b0 : sat_q),
    .acc_o      (acc_d),
    .is_digit_o (is_digit),
    .ovf_o      (ovf)
  );

  always_comb begin
    multi = (tag_s_i & tag_e_i) | (tag_s_i & value_s_i) | (tag_s_i & value_e_i) |
            (tag_e_i & value_s_i) | (tag_e_i & value_e_i) | (value_s_i & value_e_i);
    slot_free = !valid_q || field_ready_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      sat_q        <= 1'b0;
      digit_seen_q <= 1'b0;
      len_q        <= '0;
      buf_q        <= '0;
      err_q        <= '0;
      valid_q      <= 1'b0;
      otag_q       <= '0;
      olen_q       <= '0;
      odata_q      <= '0;
      oerr_q       <= '0;
      drop_q       <= 1'b0;
      perr_q       <= 1'b0;
      dcnt_q       <= '0;
    end else begin
      drop_q <= 1'b0;
      perr_q <= 1'b0;
      if (valid_q && field_ready_i) begin
        valid_q <= 1'b0;
      end

      if (multi) begin
        perr_q  <= 1'b1;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (tag_s_i) begin
              acc_q        <= acc_d;
              sat_q        <= ovf;
              digit_seen_q <= is_digit;
              len_q        <= '0;
              buf_q        <= '0;
              err_q        <= '0;
              err_q[ERR_BAD_DIGIT] <= !is_digit;
              state_q      <= TAG;
            end else if (tag_e_i || value_s_i || value_e_i) begin
              perr_q <= 1'b1;
            end
          end

          TAG: begin
            if (tag_s_i) begin
              acc_q        <= acc_d;
              sat_q        <= sat_q | ovf;
              digit_seen_q <= digit_seen_q | is_digit;
              err_q[ERR_BAD_DIGIT] <= err_q[ERR_BAD_DIGIT] | !is_digit;
              err_q[ERR_TAG_OVF]   <= err_q[ERR_TAG_OVF] | ovf;
            end else if (tag_e_i) begin
              if (!digit_seen_q) begin
                err_q[ERR_EMPTY_TAG] <= 1'b1;
              end
              state_q <= VALUE;
            end else if (value_s_i || value_e_i) begin
              perr_q  <= 1'b1;
              state_q <= IDLE;
            end
          end

          VALUE: begin
            if (value_s_i) begin
              if (len_q < LEN_W'(MAX_VAL_LEN)) begin
                buf_q[len_q*8 +: 8] <= data_i;
                len_q               <= len_q + LEN_W'(1);
              end else begin
                err_q[ERR_TRUNC] <= 1'b1;
              end
            end else if (value_e_i) begin
              if (slot_free) begin
                valid_q <= 1'b1;
                otag_q  <= acc_q;
                olen_q  <= len_q;
                odata_q <= buf_q;
                oerr_q  <= err_q;
              end else begin
                drop_q <= 1'b1;
                if (dcnt_q != 16'hFFFF) begin
                  dcnt_q <= dcnt_q + 16'd1;
                end
              end
              state_q <= IDLE;
            end else if (tag_s_i || tag_e_i) begin
              perr_q  <= 1'b1;
              state_q <= IDLE;
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign field_valid_o = valid_q;
  assign field_tag_o   = otag_q;
  assign field_len_o   = olen_q;
  assign field_data_o  = odata_q;
  assign field_err_o   = oerr_q;
  assign drop_o        = drop_q;
  assign proto_err_o   = perr_q;
  assign drop_cnt_o    = dcnt_q;

endmodule

// File: tb/tb_fix_field_extractor.sv
// tb/tb_fix_field_extractor.sv - directed table plus handshake/reset sequences for fix_field_extractor
module tb_fix_field_extractor;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   data_i;
  logic         tag_s_i, tag_e_i, value_s_i, value_e_i;
  logic         field_valid_o;
  logic         field_ready_i;
  logic [15:0]  field_tag_o;
  logic [4:0]   field_len_o;
  logic [127:0] field_data_o;
  logic [3:0]   field_err_o;
  logic         drop_o;
  logic         proto_err_o;
  logic [15:0]  drop_cnt_o;

  int total = 0;
  int bad   = 0;

  fix_field_extractor dut (
    .clk           (clk),
    .rst           (rst),
    .data_i        (data_i),
    .tag_s_i       (tag_s_i),
    .tag_e_i       (tag_e_i),
    .value_s_i     (value_s_i),
    .value_e_i     (value_e_i),
    .field_valid_o (field_valid_o),
    .field_ready_i (field_ready_i),
    .field_tag_o   (field_tag_o),
    .field_len_o   (field_len_o),
    .field_data_o  (field_data_o),
    .field_err_o   (field_err_o),
    .drop_o        (drop_o),
    .proto_err_o   (proto_err_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    string       val;
    logic [15:0] etag;
    logic [4:0]  elen;
    logic [3:0]  eerr;
    string       edata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of strobes, then look at the registered result 1ns after the edge.
  task automatic cyc(input logic ts, input logic te, input logic vs, input logic ve, input logic [7:0] d);
    tag_s_i = ts; tag_e_i = te; value_s_i = vs; value_e_i = ve; data_i = d;
    @(posedge clk);
    #1;
    tag_s_i = 1'b0; tag_e_i = 1'b0; value_s_i = 1'b0; value_e_i = 1'b0; data_i = 8'h00;
  endtask

  task automatic send_body(input string t, input string v);
    for (int i = 0; i < t.len(); i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, t[i]);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h3D);
    for (int i = 0; i < v.len(); i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, v[i]);
  endtask

  task automatic send_end();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
  endtask

  function automatic logic [127:0] pack(input string s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < s.len() && i < 16; i++) r[i*8 +: 8] = s[i];
    return r;
  endfunction

  initial begin
    vecs[0] = '{"35",      "D",                    16'd35,   5'd1,  4'b0000, "D"};
    vecs[1] = '{"9999999", "A",                    16'hFFFF, 5'd1,  4'b0010, "A"};
    vecs[2] = '{"3X",      "1",                    16'd3,    5'd1,  4'b0001, "1"};
    vecs[3] = '{"X",       "1",                    16'd0,    5'd1,  4'b1001, "1"};
    vecs[4] = '{"58",      "ABCDEFGHIJKLMNOPQRST", 16'd58,   5'd16, 4'b0100, "ABCDEFGHIJKLMNOP"};
    vecs[5] = '{"65535",   "",                     16'hFFFF, 5'd0,  4'b0000, ""};
    vecs[6] = '{"65536",   "q",                    16'hFFFF, 5'd1,  4'b0010, "q"};
    vecs[7] = '{"16",      "ABCDEFGHIJKLMNOP",     16'd16,   5'd16, 4'b0000, "ABCDEFGHIJKLMNOP"};

    rst = 1'b0; field_ready_i = 1'b0;
    tag_s_i = 1'b0; tag_e_i = 1'b0; value_s_i = 1'b0; value_e_i = 1'b0; data_i = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    chk("rst_valid", 128'(field_valid_o), 128'd0);
    chk("rst_tag",   128'(field_tag_o),   128'd0);
    chk("rst_len",   128'(field_len_o),   128'd0);
    chk("rst_data",  field_data_o,        128'd0);
    chk("rst_err",   128'(field_err_o),   128'd0);
    chk("rst_drop",  128'(drop_o),        128'd0);
    chk("rst_perr",  128'(proto_err_o),   128'd0);
    chk("rst_dcnt",  128'(drop_cnt_o),    128'd0);

    field_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send_body(vecs[k].tag, vecs[k].val);
      chk($sformatf("v%0d_pre_valid", k), 128'(field_valid_o), 128'd0);
      send_end();
      chk($sformatf("v%0d_valid", k), 128'(field_valid_o), 128'd1);
      chk($sformatf("v%0d_tag", k),   128'(field_tag_o),   128'(vecs[k].etag));
      chk($sformatf("v%0d_len", k),   128'(field_len_o),   128'(vecs[k].elen));
      chk($sformatf("v%0d_data", k),  field_data_o,        pack(vecs[k].edata));
      chk($sformatf("v%0d_err", k),   128'(field_err_o),   128'(vecs[k].eerr));
      chk($sformatf("v%0d_drop", k),  128'(drop_o),        128'd0);
    end

    // Terminators arriving in IDLE are protocol errors and never produce a record.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h3D);
    chk("idle_eq_perr", 128'(proto_err_o), 128'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h35);
    chk("idle_vs_perr", 128'(proto_err_o), 128'd1);
    send_end();
    chk("idle_ve_perr", 128'(proto_err_o), 128'd1);
    chk("idle_no_rec",  128'(field_valid_o), 128'd0);

    // Two strobes at once abort; a lone value strobe inside TAG aborts too.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h34);
    chk("tag_no_perr", 128'(proto_err_o), 128'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h34);
    chk("multi_perr", 128'(proto_err_o), 128'd1);
    send_end();
    chk("multi_then_idle", 128'(proto_err_o), 128'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h34);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h41);
    chk("tag_vs_perr", 128'(proto_err_o), 128'd1);
    chk("abort_no_rec", 128'(field_valid_o), 128'd0);

    // Full slot: second field is dropped while the first stays put.
    field_ready_i = 1'b0;
    send_body("8", "F"); send_end();
    chk("hold_valid", 128'(field_valid_o), 128'd1);
    chk("hold_tag",   128'(field_tag_o),   128'd8);
    send_body("9", "5");
    chk("hold_stable_tag",  128'(field_tag_o),  128'd8);
    chk("hold_stable_data", field_data_o,       128'h46);
    send_end();
    chk("drop_pulse", 128'(drop_o),       128'd1);
    chk("drop_cnt",   128'(drop_cnt_o),   128'd1);
    chk("drop_keep_tag",  128'(field_tag_o),  128'd8);
    chk("drop_keep_data", field_data_o,       128'h46);
    chk("drop_keep_len",  128'(field_len_o),  128'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("drop_one_cycle", 128'(drop_o), 128'd0);
    field_ready_i = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("drain_valid", 128'(field_valid_o), 128'd0);

    // Ready rising in the commit cycle frees the slot: no drop, second record loads.
    field_ready_i = 1'b0;
    send_body("8", "F"); send_end();
    send_body("9", "5");
    field_ready_i = 1'b1;
    send_end();
    chk("same_cyc_valid", 128'(field_valid_o), 128'd1);
    chk("same_cyc_tag",   128'(field_tag_o),   128'd9);
    chk("same_cyc_data",  field_data_o,        128'h35);
    chk("same_cyc_drop",  128'(drop_o),        128'd0);
    chk("same_cyc_dcnt",  128'(drop_cnt_o),    128'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("same_cyc_drain", 128'(field_valid_o), 128'd0);

    // Reset mid-VALUE with a held record clears everything.
    field_ready_i = 1'b0;
    send_body("7", "a"); send_end();
    send_body("12", "b");
    chk("pre_rst_valid", 128'(field_valid_o), 128'd1);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    chk("mid_rst_valid", 128'(field_valid_o), 128'd0);
    chk("mid_rst_dcnt",  128'(drop_cnt_o),    128'd0);
    chk("mid_rst_tag",   128'(field_tag_o),   128'd0);
    field_ready_i = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
    chk("post_rst_ve_perr", 128'(proto_err_o), 128'd1);
    send_body("55", "2"); send_end();
    chk("post_rst_valid", 128'(field_valid_o), 128'd1);
    chk("post_rst_tag",   128'(field_tag_o),   128'd55);
    chk("post_rst_len",   128'(field_len_o),   128'd1);
    chk("post_rst_data",  field_data_o,        128'h32);
    chk("post_rst_err",   128'(field_err_o),   128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
